// File: rtl/rtc_access_arbiter_pkg.sv
// Shared types and constants for the RTC access arbiter: FSM state encoding,
// poll address table and data widths.
package rtc_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int POLL_COUNT = 9;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Time/date registers sit at 33..38, the status block at 65..67.
  function automatic logic [DATA_W-1:0] poll_addr(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] addr;
    case (idx)
      4'd0:    addr = 8'd33;
      4'd1:    addr = 8'd34;
      4'd2:    addr = 8'd35;
      4'd3:    addr = 8'd36;
      4'd4:    addr = 8'd37;
      4'd5:    addr = 8'd38;
      4'd6:    addr = 8'd65;
      4'd7:    addr = 8'd66;
      4'd8:    addr = 8'd67;
      default: addr = 8'd33;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/rtc_access_arbiter_if.sv
// Host-side request bus and downstream RTC controller bus of the arbiter.
// master drives the request, slave answers it.
interface rtc_access_arbiter_if;
  import rtc_arb_pkg::*;

  logic              host_req;
  logic              host_wr;
  logic [DATA_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_err;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_wr, host_addr, host_wdata,
    input  host_ack, host_err, host_rdata
  );

  modport slave (
    input  host_req, host_wr, host_addr, host_wdata,
    output host_ack, host_err, host_rdata
  );
endinterface

interface rtc_bus_if;
  import rtc_arb_pkg::*;

  logic              rtc_req;
  logic              rtc_wr;
  logic [DATA_W-1:0] rtc_addr;
  logic [DATA_W-1:0] rtc_wdata;
  logic              rtc_done;
  logic [DATA_W-1:0] rtc_rdata;

  modport master (
    output rtc_req, rtc_wr, rtc_addr, rtc_wdata,
    input  rtc_done, rtc_rdata
  );

  modport slave (
    input  rtc_req, rtc_wr, rtc_addr, rtc_wdata,
    output rtc_done, rtc_rdata
  );
endinterface

// File: rtl/rtc_access_arbiter_poll_timer.sv
// Free-running poll period counter; tick is high in the last cycle of each
// POLL_PERIOD-cycle window.
module rtc_poll_timer #(
  parameter int POLL_PERIOD = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_access_arbiter.sv
// Arbitrates host register accesses and periodic shadow polling onto a single
// RTC controller port. Optional WAIT timeout: define RTC_ARB_TIMEOUT_EN.
module rtc_access_arbiter
  import rtc_arb_pkg::*;
#(
  parameter int POLL_PERIOD = 1000000,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  rtc_access_arbiter_if.slave       host,
  rtc_bus_if.master                 rtc,
  output logic [8*POLL_COUNT-1:0]   shadow,
  output logic                      snap_valid,
  output logic                      snap_err,
  output logic                      poll_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POLL_COUNT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             grant_host;
  logic             sweep_active;
  logic             poll_pending;
  logic             tick;
  logic             sweep_start;
  logic             last_poll;
  logic             timeout;
  logic             txn_err;
  logic             sweep_err;
  logic [IDX_W-1:0] poll_idx;

  rtc_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign sweep_start = (state == IDLE) && !host.host_req && poll_pending && !sweep_active;
  assign last_poll   = !grant_host && (poll_idx == LAST_IDX);

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // A done arriving in the final allowed cycle still completes normally.
  assign timeout = (state == WAIT) && !rtc.rtc_done &&
                   (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      txn_err   <= 1'b0;
      sweep_err <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == ISSUE) begin
        txn_err <= 1'b0;
      end else if (timeout) begin
        txn_err <= 1'b1;
      end
      if (timeout && !grant_host) begin
        sweep_err <= 1'b1;
      end else if ((state == GAP) && last_poll) begin
        sweep_err <= 1'b0;
      end
    end
  end
`else
  // Parameter stays on the port list so both builds share one instantiation.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout   = 1'b0;
  assign txn_err   = 1'b0;
  assign sweep_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host.host_req || poll_pending || sweep_active) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rtc.rtc_done || timeout) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rtc.rtc_req   = (state == WAIT);
    host.host_ack = (state == GAP) && grant_host;
    host.host_err = (state == GAP) && grant_host && txn_err;
    snap_valid    = (state == GAP) && last_poll;
    snap_err      = (state == GAP) && last_poll && sweep_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_host      <= 1'b0;
      poll_idx        <= '0;
      sweep_active    <= 1'b0;
      poll_pending    <= 1'b0;
      poll_overrun    <= 1'b0;
      rtc.rtc_wr      <= 1'b0;
      rtc.rtc_addr    <= '0;
      rtc.rtc_wdata   <= '0;
      host.host_rdata <= '0;
      shadow          <= '0;
    end else begin
      // A tick coinciding with sweep start wins, leaving a fresh pending poll.
      if (tick) begin
        poll_pending <= 1'b1;
      end else if (sweep_start) begin
        poll_pending <= 1'b0;
      end
      if (tick && (poll_pending || sweep_active)) begin
        poll_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          grant_host <= host.host_req;
          if (sweep_start) begin
            sweep_active <= 1'b1;
          end
        end
        ISSUE: begin
          rtc.rtc_wr    <= grant_host ? host.host_wr    : 1'b0;
          rtc.rtc_addr  <= grant_host ? host.host_addr  : poll_addr(poll_idx);
          rtc.rtc_wdata <= grant_host ? host.host_wdata : '0;
        end
        WAIT: begin
          if (rtc.rtc_done) begin
            if (grant_host && !rtc.rtc_wr) begin
              host.host_rdata <= rtc.rtc_rdata;
            end
            if (!grant_host) begin
              shadow[{poll_idx, 3'b000} +: DATA_W] <= rtc.rtc_rdata;
            end
          end
        end
        GAP: begin
          // Host accesses leave the sweep index untouched so polling resumes.
          if (!grant_host) begin
            if (poll_idx == LAST_IDX) begin
              poll_idx     <= '0;
              sweep_active <= 1'b0;
            end else begin
              poll_idx <= poll_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
